// File: rtl/sd_card_pkg.sv
// rtl/sd_card_pkg.sv - shared state codes, token codes and CRC16 helper for the SD card responder
package sd_card_pkg;

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_RD_NAC   = 4'd1;
    localparam logic [3:0] ST_RD_START = 4'd2;
    localparam logic [3:0] ST_RD_DATA  = 4'd3;
    localparam logic [3:0] ST_RD_CRC   = 4'd4;
    localparam logic [3:0] ST_RD_END   = 4'd5;
    localparam logic [3:0] ST_WR_WAIT  = 4'd6;
    localparam logic [3:0] ST_WR_DATA  = 4'd7;
    localparam logic [3:0] ST_WR_CRC   = 4'd8;
    localparam logic [3:0] ST_WR_END   = 4'd9;
    localparam logic [3:0] ST_WR_GAP   = 4'd10;
    localparam logic [3:0] ST_WR_TOKEN = 4'd11;
    localparam logic [3:0] ST_WR_BUSY  = 4'd12;

    localparam logic [2:0] TOKEN_OK  = 3'b010;
    localparam logic [2:0] TOKEN_BAD = 3'b101;

    // x^16 + x^12 + x^5 + 1
    localparam logic [15:0] CRC16_POLY = 16'h1021;

    // One serial CRC16 step, data bit shifted in at the top.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
        logic fb;
        fb = crc[15] ^ din;
        return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/sd_crc_16.sv
// rtl/sd_crc_16.sv - serial CRC16 for one DAT lane; feeding back its own MSB shifts the remainder out
module sd_crc_16
    import sd_card_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    input  logic i_bit,
    output logic o_msb
);
    logic [15:0] r_crc;

    // Clear has priority so a new block always starts from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_crc <= 16'h0000;
        end else if (i_clr) begin
            r_crc <= 16'h0000;
        end else if (i_en) begin
            r_crc <= crc16_step(r_crc, i_bit);
        end
    end

    assign o_msb = r_crc[15];

endmodule

// File: rtl/sd_card_data_responder.sv
// rtl/sd_card_data_responder.sv - SD card-side DAT responder (read source / write sink); optional SD_CARD_CRC_INJECT_EN
module sd_card_data_responder
    import sd_card_pkg::*;
#(
    parameter int NAC       = 2,
    parameter int BLKSIZE_W = 12
) (
    input  logic                 sd_clk,
    input  logic                 rst,
    input  logic                 bus_4bit_i,
    input  logic [BLKSIZE_W-1:0] blksize_i,
    input  logic [15:0]          busy_cycles_i,
    input  logic                 start_read_i,
    input  logic                 start_write_i,
    input  logic                 abort_i,
`ifdef SD_CARD_CRC_INJECT_EN
    input  logic                 inject_crc_err_i,
`endif
    input  logic [3:0]           dat_i,
    output logic [3:0]           dat_o,
    output logic                 dat_oe_o,
    output logic                 rd_data_req_o,
    input  logic [31:0]          rd_data_i,
    output logic [31:0]          wr_data_o,
    output logic                 wr_data_valid_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 crc_ok_o
);
    localparam int              WW     = BLKSIZE_W - 2;
    localparam logic [4:0]      NAC_M1 = 5'(NAC - 1);
    localparam logic [WW-1:0]   W_ONE  = WW'(1);

    logic [3:0]    r_state;
    logic [4:0]    r_cnt;
    logic [WW-1:0] r_wleft;
    logic          r_bus4;
    logic [31:0]   r_shift;
    logic [31:0]   r_buf;
    logic          r_req_d;
    logic          r_err;
    logic [15:0]   r_bcnt;
    logic          r_done;
    logic          r_crc_ok;
    logic [31:0]   r_wr_data;
    logic          r_wr_valid;
`ifdef SD_CARD_CRC_INJECT_EN
    logic          r_inject;
`endif

    logic [3:0]    w_dat;
    logic          w_oe;
    logic          w_req;
    logic [3:0]    w_mask;
    logic [4:0]    w_cpw_m1;
    logic [3:0]    w_crc_en;
    logic [3:0]    w_crc_bit;
    logic [3:0]    w_crc_top;
    logic          w_crc_clr;
    logic [2:0]    w_tok;
    logic [31:0]   w_next_word;
    logic [31:0]   w_shift_in;
    logic          w_unused_blk;

    assign w_mask       = r_bus4 ? 4'hF : 4'h1;
    assign w_cpw_m1     = r_bus4 ? 5'd7 : 5'd31;
    assign w_tok        = r_err ? TOKEN_BAD : TOKEN_OK;
    // A word fetched in the previous cycle is not yet in r_buf; take it straight from the port.
    assign w_next_word  = r_req_d ? rd_data_i : r_buf;
    assign w_shift_in   = r_bus4 ? {r_shift[27:0], dat_i} : {r_shift[30:0], dat_i[0]};
    assign w_crc_clr    = abort_i | ((r_state == ST_IDLE) & (start_read_i | start_write_i));
    assign w_unused_blk = ^blksize_i[1:0];

    for (genvar g = 0; g < 4; g++) begin : g_crc
        sd_crc_16 u_crc (
            .clk   (sd_clk),
            .rst   (rst),
            .i_clr (w_crc_clr),
            .i_en  (w_crc_en[g]),
            .i_bit (w_crc_bit[g]),
            .o_msb (w_crc_top[g])
        );
    end

    // Bus drive, word requests and CRC lane control decoded from the current state.
    always_comb begin
        w_dat     = 4'hF;
        w_oe      = 1'b0;
        w_req     = 1'b0;
        w_crc_en  = 4'h0;
        w_crc_bit = 4'h0;
        case (r_state)
            ST_RD_NAC: begin
                w_req = (r_cnt == NAC_M1);
            end
            ST_RD_START: begin
                w_oe  = 1'b1;
                w_dat = ~w_mask;
            end
            ST_RD_DATA: begin
                w_oe      = 1'b1;
                w_dat     = r_bus4 ? r_shift[31:28] : {3'b111, r_shift[31]};
                w_crc_en  = w_mask;
                w_crc_bit = w_dat;
                w_req     = (r_cnt == 5'd2) && (r_wleft != W_ONE);
            end
            ST_RD_CRC: begin
                w_oe      = 1'b1;
                w_dat     = w_crc_top | ~w_mask;
                w_crc_en  = w_mask;
                w_crc_bit = w_crc_top;
`ifdef SD_CARD_CRC_INJECT_EN
                if (r_inject && (r_cnt == 5'd0)) begin
                    w_dat[0] = ~w_dat[0];
                end
`endif
            end
            ST_RD_END: begin
                w_oe = 1'b1;
            end
            ST_WR_DATA: begin
                w_crc_en  = w_mask;
                w_crc_bit = dat_i;
            end
            ST_WR_CRC: begin
                w_crc_en  = w_mask;
                w_crc_bit = w_crc_top;
            end
            ST_WR_TOKEN: begin
                w_oe = 1'b1;
                if (r_cnt == 5'd4) begin
                    w_dat[0] = 1'b0;
                end else if (r_cnt == 5'd0) begin
                    w_dat[0] = 1'b1;
                end else begin
                    w_dat[0] = w_tok[r_cnt[1:0] - 2'd1];
                end
            end
            ST_WR_BUSY: begin
                w_oe     = 1'b1;
                w_dat[0] = (r_bcnt == 16'd0);
            end
            default: begin
                w_oe = 1'b0;
            end
        endcase
    end

    // Block sequencing for both directions; abort wins over everything.
    always_ff @(posedge sd_clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 5'd0;
            r_wleft    <= '0;
            r_bus4     <= 1'b0;
            r_shift    <= 32'h0;
            r_buf      <= 32'h0;
            r_req_d    <= 1'b0;
            r_err      <= 1'b0;
            r_bcnt     <= 16'd0;
            r_done     <= 1'b0;
            r_crc_ok   <= 1'b0;
            r_wr_data  <= 32'h0;
            r_wr_valid <= 1'b0;
`ifdef SD_CARD_CRC_INJECT_EN
            r_inject   <= 1'b0;
`endif
        end else begin
            r_done     <= 1'b0;
            r_wr_valid <= 1'b0;
            r_req_d    <= w_req;
            if (r_req_d) begin
                r_buf <= rd_data_i;
            end
            if (abort_i) begin
                r_state <= ST_IDLE;
                r_err   <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start_read_i || start_write_i) begin
                            r_state <= start_read_i ? ST_RD_NAC : ST_WR_WAIT;
                            r_cnt   <= NAC_M1;
                            r_bus4  <= bus_4bit_i;
                            r_wleft <= blksize_i[BLKSIZE_W-1:2];
                            r_err   <= 1'b0;
`ifdef SD_CARD_CRC_INJECT_EN
                            r_inject <= start_read_i & inject_crc_err_i;
`endif
                        end
                    end
                    ST_RD_NAC: begin
                        if (r_cnt == 5'd0) r_state <= ST_RD_START;
                        else               r_cnt   <= r_cnt - 5'd1;
                    end
                    ST_RD_START: begin
                        if (r_wleft == '0) begin
                            r_state <= ST_RD_CRC;
                            r_cnt   <= 5'd15;
                        end else begin
                            r_state <= ST_RD_DATA;
                            r_shift <= w_next_word;
                            r_cnt   <= w_cpw_m1;
                        end
                    end
                    ST_RD_DATA: begin
                        if (r_cnt != 5'd0) begin
                            r_shift <= r_bus4 ? {r_shift[27:0], 4'h0} : {r_shift[30:0], 1'b0};
                            r_cnt   <= r_cnt - 5'd1;
                        end else if (r_wleft == W_ONE) begin
                            r_state <= ST_RD_CRC;
                            r_cnt   <= 5'd15;
                        end else begin
                            r_shift <= w_next_word;
                            r_wleft <= r_wleft - W_ONE;
                            r_cnt   <= w_cpw_m1;
                        end
                    end
                    ST_RD_CRC: begin
                        if (r_cnt == 5'd0) r_state <= ST_RD_END;
                        else               r_cnt   <= r_cnt - 5'd1;
                    end
                    ST_RD_END: begin
                        r_state  <= ST_IDLE;
                        r_done   <= 1'b1;
                        r_crc_ok <= 1'b1;
                    end
                    ST_WR_WAIT: begin
                        if (!dat_i[0]) begin
                            r_state <= (r_wleft == '0) ? ST_WR_CRC : ST_WR_DATA;
                            r_cnt   <= (r_wleft == '0) ? 5'd15 : w_cpw_m1;
                        end
                    end
                    ST_WR_DATA: begin
                        r_shift <= w_shift_in;
                        if (r_cnt != 5'd0) begin
                            r_cnt <= r_cnt - 5'd1;
                        end else begin
                            r_wr_data  <= w_shift_in;
                            r_wr_valid <= 1'b1;
                            if (r_wleft == W_ONE) begin
                                r_state <= ST_WR_CRC;
                                r_cnt   <= 5'd15;
                            end else begin
                                r_wleft <= r_wleft - W_ONE;
                                r_cnt   <= w_cpw_m1;
                            end
                        end
                    end
                    ST_WR_CRC: begin
                        if (((dat_i ^ w_crc_top) & w_mask) != 4'h0) r_err <= 1'b1;
                        if (r_cnt == 5'd0) r_state <= ST_WR_END;
                        else               r_cnt   <= r_cnt - 5'd1;
                    end
                    ST_WR_END: begin
                        if ((~dat_i & w_mask) != 4'h0) r_err <= 1'b1;
                        r_state <= ST_WR_GAP;
                        r_cnt   <= 5'd1;
                    end
                    ST_WR_GAP: begin
                        if (r_cnt == 5'd0) begin
                            r_state <= ST_WR_TOKEN;
                            r_cnt   <= 5'd4;
                        end else begin
                            r_cnt <= r_cnt - 5'd1;
                        end
                    end
                    ST_WR_TOKEN: begin
                        if (r_cnt != 5'd0) begin
                            r_cnt <= r_cnt - 5'd1;
                        end else if (!r_err && (busy_cycles_i != 16'd0)) begin
                            r_state <= ST_WR_BUSY;
                            r_bcnt  <= busy_cycles_i;
                        end else begin
                            r_state  <= ST_IDLE;
                            r_done   <= 1'b1;
                            r_crc_ok <= ~r_err;
                        end
                    end
                    ST_WR_BUSY: begin
                        if (r_bcnt == 16'd0) begin
                            r_state  <= ST_IDLE;
                            r_done   <= 1'b1;
                            r_crc_ok <= 1'b1;
                        end else begin
                            r_bcnt <= r_bcnt - 16'd1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign dat_o           = w_dat;
    assign dat_oe_o        = w_oe;
    assign rd_data_req_o   = w_req;
    assign wr_data_o       = r_wr_data;
    assign wr_data_valid_o = r_wr_valid;
    assign busy_o          = (r_state != ST_IDLE);
    assign done_o          = r_done;
    assign crc_ok_o        = r_crc_ok;

endmodule

// File: tb/tb_sd_card_data_responder.sv
// tb/tb_sd_card_data_responder.sv - host-side bench for sd_card_data_responder
module tb_sd_card_data_responder;

    localparam int NAC = 2;

    logic        sd_clk;
    logic        rst;
    logic        bus_4bit_i;
    logic [11:0] blksize_i;
    logic [15:0] busy_cycles_i;
    logic        start_read_i;
    logic        start_write_i;
    logic        abort_i;
    logic [3:0]  dat_i;
    logic [3:0]  dat_o;
    logic        dat_oe_o;
    logic        rd_data_req_o;
    logic [31:0] rd_data_i;
    logic [31:0] wr_data_o;
    logic        wr_data_valid_o;
    logic        busy_o;
    logic        done_o;
    logic        crc_ok_o;

    int          n_tests;
    int          n_fail;
    logic [31:0] sb[$];
    int          rd_nreq;
    int          rd_k;

    sd_card_data_responder #(.NAC(NAC), .BLKSIZE_W(12)) dut (
        .sd_clk          (sd_clk),
        .rst             (rst),
        .bus_4bit_i      (bus_4bit_i),
        .blksize_i       (blksize_i),
        .busy_cycles_i   (busy_cycles_i),
        .start_read_i    (start_read_i),
        .start_write_i   (start_write_i),
        .abort_i         (abort_i),
`ifdef SD_CARD_CRC_INJECT_EN
        .inject_crc_err_i(1'b0),
`endif
        .dat_i           (dat_i),
        .dat_o           (dat_o),
        .dat_oe_o        (dat_oe_o),
        .rd_data_req_o   (rd_data_req_o),
        .rd_data_i       (rd_data_i),
        .wr_data_o       (wr_data_o),
        .wr_data_valid_o (wr_data_valid_o),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .crc_ok_o        (crc_ok_o)
    );

    initial sd_clk = 1'b0;
    always #5 sd_clk = ~sd_clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic b);
        logic [15:0] n;
        n = {c[14:0], 1'b0};
        if (c[15] ^ b) n = n ^ 16'h1021;
        return n;
    endfunction

    function automatic logic [31:0] rd_word(input int k);
        return 32'h00010203 + 32'h04040404 * 32'(k);
    endfunction

    task automatic tick();
        @(posedge sd_clk);
        @(negedge sd_clk);
    endtask

    // Advance one cycle and answer any word request with the next pattern word.
    task automatic tick_rd();
        tick();
        if (rd_data_req_o) begin
            rd_nreq++;
            rd_data_i = rd_word(rd_k);
            sb.push_back(rd_data_i);
            rd_k++;
        end
    endtask

    task automatic host_read(input bit bus4, input int blk, input bit also_wr, input bit mid_wr, input string tag);
        logic [3:0]  mask;
        logic [15:0] hc[4];
        logic [15:0] rc[4];
        logic [31:0] acc;
        logic [31:0] exp;
        int          nw, cpw, lat, extra_done, extra_busy;
        mask = bus4 ? 4'hF : 4'h1;
        nw   = blk / 4;
        cpw  = bus4 ? 8 : 32;
        for (int i = 0; i < 4; i++) begin hc[i] = 16'h0; rc[i] = 16'h0; end
        rd_nreq = 0; rd_k = 0; sb.delete();
        bus_4bit_i = bus4; blksize_i = 12'(blk);
        start_read_i = 1'b1; start_write_i = also_wr;
        lat = 0;
        do begin
            tick_rd();
            lat++;
            start_read_i = 1'b0; start_write_i = 1'b0;
        end while (!(dat_oe_o && ((dat_o & mask) == 4'h0)) && lat < 40);
        n_tests++;
        if (lat !== NAC + 1) begin n_fail++; $display("FAIL %s start_latency got %0d want %0d", tag, lat, NAC + 1); end
        n_tests++;
        if (dat_o !== ~mask) begin n_fail++; $display("FAIL %s start_bit got %h want %h", tag, dat_o, ~mask); end
        start_write_i = mid_wr;
        for (int w = 0; w < nw; w++) begin
            acc = 32'h0;
            for (int c = 0; c < cpw; c++) begin
                tick_rd();
                start_write_i = 1'b0;
                acc = bus4 ? {acc[27:0], dat_o} : {acc[30:0], dat_o[0]};
                for (int i = 0; i < 4; i++) if (mask[i]) hc[i] = crc_upd(hc[i], dat_o[i]);
            end
            exp = (sb.size() > 0) ? sb.pop_front() : 32'hDEADDEAD;
            if (acc !== exp) begin n_tests++; n_fail++; $display("FAIL %s word%0d got %h want %h", tag, w, acc, exp); end
        end
        n_tests++;
        start_write_i = 1'b0;
        for (int b = 0; b < 16; b++) begin
            tick_rd();
            for (int i = 0; i < 4; i++) rc[i] = {rc[i][14:0], dat_o[i]};
        end
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                n_tests++;
                if (rc[i] !== hc[i]) begin n_fail++; $display("FAIL %s crc_lane%0d got %h want %h", tag, i, rc[i], hc[i]); end
            end
        end
        tick_rd();
        n_tests++;
        if ({dat_oe_o, dat_o} !== 5'h1F) begin n_fail++; $display("FAIL %s end_bit got oe=%b dat=%h want oe=1 dat=f", tag, dat_oe_o, dat_o); end
        tick_rd();
        n_tests++;
        if ({dat_oe_o, done_o, crc_ok_o} !== 3'b011) begin
            n_fail++; $display("FAIL %s completion got oe=%b done=%b crc_ok=%b want 0 1 1", tag, dat_oe_o, done_o, crc_ok_o);
        end
        n_tests++;
        if (rd_nreq !== ((nw == 0) ? 1 : nw)) begin n_fail++; $display("FAIL %s req_count got %0d want %0d", tag, rd_nreq, (nw == 0) ? 1 : nw); end
        extra_done = 0; extra_busy = 0;
        repeat (4) begin tick(); if (done_o) extra_done++; if (busy_o) extra_busy++; end
        n_tests++;
        if (extra_done !== 0 || extra_busy !== 0) begin
            n_fail++; $display("FAIL %s after_done got done=%0d busy=%0d want 0 0", tag, extra_done, extra_busy);
        end
        sb.delete();
    endtask

    task automatic host_write(input bit bus4, input int blk, input int busy, input int flip_lane, input string tag,
                              output int gap, output logic [4:0] tok, output int nbusy, output logic rel,
                              output logic done_seen, output logic oe_after);
        logic [3:0]  mask;
        logic [3:0]  d;
        logic [15:0] hc[4];
        logic [31:0] word, sh, exp;
        int          nw, cpw, nvalid;
        mask = bus4 ? 4'hF : 4'h1;
        nw = blk / 4; cpw = bus4 ? 8 : 32;
        for (int i = 0; i < 4; i++) hc[i] = 16'h0;
        sb.delete(); nvalid = 0;
        bus_4bit_i = bus4; blksize_i = 12'(blk); busy_cycles_i = 16'(busy); dat_i = 4'hF;
        start_write_i = 1'b1; tick(); start_write_i = 1'b0;
        tick(); tick();
        dat_i = bus4 ? 4'h0 : 4'hE;
        tick();
        for (int w = 0; w < nw; w++) begin
            word = $urandom;
            sb.push_back(word);
            sh = word;
            for (int c = 0; c < cpw; c++) begin
                d = bus4 ? sh[31:28] : {3'b111, sh[31]};
                sh = bus4 ? (sh << 4) : (sh << 1);
                for (int i = 0; i < 4; i++) if (mask[i]) hc[i] = crc_upd(hc[i], d[i]);
                dat_i = d;
                tick();
                if (wr_data_valid_o) begin
                    nvalid++; exp = (sb.size() > 0) ? sb.pop_front() : 32'hDEADDEAD;
                    n_tests++;
                    if (wr_data_o !== exp) begin n_fail++; $display("FAIL %s wr_word got %h want %h", tag, wr_data_o, exp); end
                end
            end
        end
        for (int b = 0; b < 16; b++) begin
            d = 4'hF;
            for (int i = 0; i < 4; i++) begin
                if (mask[i]) begin
                    d[i] = hc[i][15 - b];
                    if (i == flip_lane && b == 5) d[i] = ~d[i];
                end
            end
            dat_i = d;
            tick();
            if (wr_data_valid_o) begin
                nvalid++; exp = (sb.size() > 0) ? sb.pop_front() : 32'hDEADDEAD;
                n_tests++;
                if (wr_data_o !== exp) begin n_fail++; $display("FAIL %s wr_word got %h want %h", tag, wr_data_o, exp); end
            end
        end
        n_tests++;
        if (nvalid !== nw) begin n_fail++; $display("FAIL %s wr_valid_count got %0d want %0d", tag, nvalid, nw); end
        dat_i = 4'hF;
        tick();
        gap = 0;
        while (!dat_oe_o && gap < 10) begin gap++; tick(); end
        tok = 5'h0;
        for (int t = 0; t < 5; t++) begin
            tok = {tok[3:0], dat_o[0]};
            if (t < 4) tick();
        end
        tick();
        nbusy = 0;
        while (dat_oe_o && !dat_o[0] && nbusy < 1000) begin nbusy++; tick(); end
        rel = 1'b0;
        if (dat_oe_o) begin rel = dat_o[0]; tick(); end
        done_seen = done_o;
        oe_after  = dat_oe_o;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge sd_clk);
        n_tests++;
        if ({dat_o, dat_oe_o, rd_data_req_o, wr_data_o, wr_data_valid_o, busy_o, done_o, crc_ok_o} !== {4'hF, 38'h0}) begin
            n_fail++;
            $display("FAIL reset_values got dat=%h oe=%b req=%b wd=%h wv=%b busy=%b done=%b ok=%b want f 0 0 0 0 0 0 0",
                     dat_o, dat_oe_o, rd_data_req_o, wr_data_o, wr_data_valid_o, busy_o, done_o, crc_ok_o);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_read_4bit();
        host_read(1'b1, 512, 1'b0, 1'b0, "read4_512");
    endtask

    task automatic test_write_1bit();
        int gap, nbusy; logic [4:0] tok; logic rel, dn, oe;
        host_write(1'b0, 8, 8, -1, "write1", gap, tok, nbusy, rel, dn, oe);
        n_tests++;
        if (gap !== 2) begin n_fail++; $display("FAIL write1 gap got %0d want 2", gap); end
        n_tests++;
        if (tok !== 5'b00101) begin n_fail++; $display("FAIL write1 token got %b want 00101", tok); end
        n_tests++;
        if (nbusy !== 8 || rel !== 1'b1) begin n_fail++; $display("FAIL write1 busy got %0d rel=%b want 8 rel=1", nbusy, rel); end
        n_tests++;
        if ({dn, oe, crc_ok_o} !== 3'b101) begin n_fail++; $display("FAIL write1 done got done=%b oe=%b ok=%b want 1 0 1", dn, oe, crc_ok_o); end
    endtask

    task automatic test_write_crc_err();
        int gap, nbusy; logic [4:0] tok; logic rel, dn, oe;
        host_write(1'b1, 16, 8, 2, "write4_bad", gap, tok, nbusy, rel, dn, oe);
        n_tests++;
        if (tok !== 5'b01011) begin n_fail++; $display("FAIL write4_bad token got %b want 01011", tok); end
        n_tests++;
        if (nbusy !== 0 || rel !== 1'b0) begin n_fail++; $display("FAIL write4_bad busy got %0d rel=%b want 0 rel=0", nbusy, rel); end
        n_tests++;
        if ({dn, oe, crc_ok_o} !== 3'b100) begin n_fail++; $display("FAIL write4_bad done got done=%b oe=%b ok=%b want 1 0 0", dn, oe, crc_ok_o); end
    endtask

    task automatic test_abort();
        int cnt, nd, gap, nbusy; logic [4:0] tok; logic rel, dn, oe;
        rd_nreq = 0; rd_k = 0; sb.delete();
        bus_4bit_i = 1'b1; blksize_i = 12'd512;
        start_read_i = 1'b1; tick_rd(); start_read_i = 1'b0;
        cnt = 0;
        while (!(dat_oe_o && dat_o == 4'h0) && cnt < 20) begin tick_rd(); cnt++; end
        for (int c = 0; c < 5 * 8 + 3; c++) tick_rd();
        abort_i = 1'b1; tick_rd(); abort_i = 1'b0;
        n_tests++;
        if ({dat_oe_o, dat_o, busy_o, crc_ok_o} !== 7'b0_1111_0_0) begin
            n_fail++; $display("FAIL abort_release got oe=%b dat=%h busy=%b ok=%b want 0 f 0 0", dat_oe_o, dat_o, busy_o, crc_ok_o);
        end
        nd = 0;
        repeat (20) begin tick(); if (done_o) nd++; end
        n_tests++;
        if (nd !== 0) begin n_fail++; $display("FAIL abort_no_done got %0d want 0", nd); end
        abort_i = 1'b1; start_read_i = 1'b1; tick(); abort_i = 1'b0; start_read_i = 1'b0;
        n_tests++;
        if (busy_o !== 1'b0) begin n_fail++; $display("FAIL abort_vs_start got busy=%b want 0", busy_o); end
        sb.delete();
        host_write(1'b0, 8, 3, -1, "abort_write", gap, tok, nbusy, rel, dn, oe);
        n_tests++;
        if (tok !== 5'b00101 || nbusy !== 3 || {dn, oe, crc_ok_o} !== 3'b101) begin
            n_fail++; $display("FAIL abort_write got tok=%b busy=%0d done=%b oe=%b ok=%b want 00101 3 1 0 1", tok, nbusy, dn, oe, crc_ok_o);
        end
    endtask

    task automatic test_start_conflict();
        host_read(1'b1, 64, 1'b1, 1'b1, "conflict");
    endtask

    task automatic test_blksize0();
        host_read(1'b1, 0, 1'b0, 1'b0, "blk0");
    endtask

    task automatic test_read_1bit();
        host_read(1'b0, 8, 1'b0, 1'b0, "read1_8");
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        rst = 1'b1; bus_4bit_i = 1'b0; blksize_i = 12'h0; busy_cycles_i = 16'h0;
        start_read_i = 1'b0; start_write_i = 1'b0; abort_i = 1'b0;
        dat_i = 4'hF; rd_data_i = 32'h0; rd_nreq = 0; rd_k = 0;
        test_reset();
        test_read_4bit();
        test_write_1bit();
        test_write_crc_err();
        test_abort();
        test_start_conflict();
        test_blksize0();
        test_read_1bit();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
